// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA raster scan generator.
// Default timing is 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam int POS_W = 10;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic display_on;
  } sync_bits_t;

endpackage

// File: rtl/scan_axis.sv
// One raster axis: a position counter with a phase FSM (ACTIVE/FRONT/SYNC/BACK).
// The counter advances on en; wrap pulses combinationally on the last position.
module scan_axis
  import vga_pkg::*;
#(
  parameter int ACTIVE_LEN = 640,
  parameter int FRONT_LEN  = 16,
  parameter int SYNC_LEN   = 96,
  parameter int BACK_LEN   = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [POS_W-1:0] pos,
  output phase_e           phase,
  output logic             wrap
);

  localparam logic [POS_W-1:0] LAST_ACTIVE = POS_W'(ACTIVE_LEN - 1);
  localparam logic [POS_W-1:0] LAST_FRONT  = POS_W'(ACTIVE_LEN + FRONT_LEN - 1);
  localparam logic [POS_W-1:0] LAST_SYNC   = POS_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
  localparam logic [POS_W-1:0] LAST_POS    =
    POS_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);

  logic [POS_W-1:0] pos_nxt;
  phase_e           phase_nxt;

  assign wrap = en && (pos == LAST_POS);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can leave it unassigned and infer a latch.
    pos_nxt   = pos;
    phase_nxt = phase;
    if (en) begin
      pos_nxt = wrap ? '0 : pos + POS_W'(1);
      case (phase)
        ACTIVE:  if (pos == LAST_ACTIVE) phase_nxt = FRONT;
        FRONT:   if (pos == LAST_FRONT)  phase_nxt = SYNC;
        SYNC:    if (pos == LAST_SYNC)   phase_nxt = BACK;
        BACK:    if (wrap)               phase_nxt = ACTIVE;
        default:                         phase_nxt = ACTIVE;
      endcase
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos   <= '0;
      phase <= ACTIVE;
    end else begin
      pos   <= pos_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: x/y/active with zero latency, sync and display_on
// delayed PIPE_DEPTH clocks to match downstream pixel pipelines, plus line/frame strobes.
module vga_scan_gen #(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FRONT    = vga_pkg::H_FRONT,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BACK     = vga_pkg::H_BACK,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FRONT    = vga_pkg::V_FRONT,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BACK     = vga_pkg::V_BACK,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_tick,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
);

  import vga_pkg::*;

  localparam logic SYNC_OFF = ~SYNC_POL;
  localparam sync_bits_t PIPE_RESET = '{hsync: SYNC_OFF, vsync: SYNC_OFF, display_on: 1'b0};

  logic [POS_W-1:0] hpos;
  logic [POS_W-1:0] vpos;
  phase_e           h_phase;
  phase_e           v_phase;
  logic             h_wrap;
  logic             v_wrap;
  sync_bits_t       raw;
  logic             unused_vpos_msb;

  scan_axis #(
    .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .pos(hpos), .phase(h_phase), .wrap(h_wrap)
  );

  scan_axis #(
    .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .en(h_wrap),
    .pos(vpos), .phase(v_phase), .wrap(v_wrap)
  );

  // y exposes only the low nine bits; lines past 511 alias and must be gated by active.
  assign x               = hpos;
  assign y               = vpos[8:0];
  assign unused_vpos_msb = vpos[9];
  assign active          = (h_phase == ACTIVE) && (v_phase == ACTIVE);

  always_comb begin
    raw.hsync      = (h_phase == SYNC) ? SYNC_POL : SYNC_OFF;
    raw.vsync      = (v_phase == SYNC) ? SYNC_POL : SYNC_OFF;
    raw.display_on = active;
  end

  generate
    if (PIPE_DEPTH == 0) begin : g_no_pipe
      assign {hsync, vsync, display_on} = raw;
    end else begin : g_pipe
      sync_bits_t stage [PIPE_DEPTH];

      // NOTE: this chain is a few flops rather than a RAM, so it is reset to inactive levels to avoid a stray pulse.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DEPTH; i++) stage[i] <= PIPE_RESET;
        end else begin
          stage[0] <= raw;
          for (int i = 1; i < PIPE_DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign {hsync, vsync, display_on} = stage[PIPE_DEPTH-1];
    end
  endgenerate

  // Strobes are registered from the wrap conditions, so they coincide with hpos==0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      line_tick  <= h_wrap;
      frame_tick <= v_wrap;
      if (v_wrap) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen: a timing model predicts every output from the
// cycle count since reset; a negedge monitor pops and compares each cycle.
module tb_vga_scan_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       active;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_tick;
    logic       frame_tick;
    logic [7:0] frame_cnt;
  } obs_t;

  typedef struct packed {
    obs_t d0;
    obs_t d2;
    obs_t sm;
    int   t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   t = 0;
  int   checks = 0;
  int   fails = 0;
  int   pushed = 0;
  int   popped = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Three instances: full timing with no delay, full timing with two-stage delay,
  // and a miniature raster (15x11) so many whole frames fit in the run.
  logic [9:0] x0, x2, xs;
  logic [8:0] y0, y2, ys;
  logic act0, hs0, vs0, don0, lt0, ft0;
  logic act2, hs2, vs2, don2, lt2, ft2;
  logic acts, hss, vss, dons, lts, fts;
  logic [7:0] fc0, fc2, fcs;
  obs_t o_d0, o_d2, o_sm;

  vga_scan_gen #(.PIPE_DEPTH(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .x(x0), .y(y0), .active(act0), .hsync(hs0), .vsync(vs0),
    .display_on(don0), .line_tick(lt0), .frame_tick(ft0), .frame_cnt(fc0)
  );

  vga_scan_gen #(.PIPE_DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .x(x2), .y(y2), .active(act2), .hsync(hs2), .vsync(vs2),
    .display_on(don2), .line_tick(lt2), .frame_tick(ft2), .frame_cnt(fc2)
  );

  vga_scan_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_POL(1'b0), .PIPE_DEPTH(1)
  ) u_sm (
    .clk(clk), .rst_n(rst_n), .x(xs), .y(ys), .active(acts), .hsync(hss), .vsync(vss),
    .display_on(dons), .line_tick(lts), .frame_tick(fts), .frame_cnt(fcs)
  );

  assign o_d0 = {x0, y0, act0, hs0, vs0, don0, lt0, ft0, fc0};
  assign o_d2 = {x2, y2, act2, hs2, vs2, don2, lt2, ft2, fc2};
  assign o_sm = {xs, ys, acts, hss, vss, dons, lts, fts, fcs};

  // Outputs t clocks after reset release, derived from the porch/sync widths directly.
  function automatic obs_t model(int tc, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb, int d);
    obs_t e;
    int ht, vt, h, v, u, hu, vu;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h  = tc % ht;
    v  = (tc / ht) % vt;
    e.x          = 10'(h);
    e.y          = 9'(v % 512);
    e.active     = (h < ha) && (v < va);
    e.line_tick  = (tc > 0) && (h == 0);
    e.frame_tick = (tc > 0) && (h == 0) && (v == 0);
    e.frame_cnt  = 8'((tc / (ht * vt)) % 256);
    if (tc < d) begin
      e.hsync      = 1'b1;
      e.vsync      = 1'b1;
      e.display_on = 1'b0;
    end else begin
      u  = tc - d;
      hu = u % ht;
      vu = (u / ht) % vt;
      e.hsync      = !((hu >= ha + hf) && (hu < ha + hf + hs));
      e.vsync      = !((vu >= va + vf) && (vu < va + vf + vs));
      e.display_on = (hu < ha) && (vu < va);
    end
    return e;
  endfunction

  function automatic exp_t expected(int tc);
    exp_t e;
    e.d0 = model(tc, 640, 16, 96, 48, 480, 10, 2, 33, 0);
    e.d2 = model(tc, 640, 16, 96, 48, 480, 10, 2, 33, 2);
    e.sm = model(tc, 8, 2, 3, 2, 6, 1, 2, 2, 1);
    e.t  = tc;
    return e;
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_reset(string name);
    exp_t e;
    e = expected(0);
    check({name, " d0"}, 64'(o_d0), 64'(e.d0));
    check({name, " d2"}, 64'(o_d2), 64'(e.d2));
    check({name, " sm"}, 64'(o_sm), 64'(e.sm));
  endtask

  task automatic run_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      t++;
      #1;
      sb_q.push_back(expected(t));
      pushed++;
    end
  endtask

  // Monitor: per-cycle scoreboard compare plus structural measurements.
  int cyc = 0;
  int hs_low = 0;
  int last_ft = -1;
  int nft = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      popped++;
      check($sformatf("d0 t=%0d", e.t), 64'(o_d0), 64'(e.d0));
      check($sformatf("d2 t=%0d", e.t), 64'(o_d2), 64'(e.d2));
      check($sformatf("sm t=%0d", e.t), 64'(o_sm), 64'(e.sm));
    end
    if (!rst_n) begin
      hs_low  = 0;
      last_ft = -1;
      nft     = 0;
    end else begin
      if (x0 == 10'd0) hs_low = 0;
      if (!hs0) hs_low++;
      if (x0 == 10'd799) check("d0 hsync low width", 64'(hs_low), 64'd96);
      if (fts) begin
        if (last_ft >= 0) check("sm frame period", 64'(cyc - last_ft), 64'd165);
        last_ft = cyc;
        nft++;
        check($sformatf("sm frame_cnt at tick %0d", nft), 64'(fcs), 64'(nft % 256));
      end
    end
  end

  initial begin
    int to_x300;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("power-on reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 257 miniature frames so frame_cnt wraps 255 -> 0.
    run_cycles(257 * 165 + 10);

    // Advance to x=300 on the full-timing instances, then reset mid-line.
    to_x300 = (300 - (t % 800) + 800) % 800;
    run_cycles(to_x300);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("async mid-frame reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset("mid-frame reset held");
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    run_cycles(2000);

    @(negedge clk);
    #1;
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);
    check("scoreboard pops", 64'(popped), 64'(pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
